set_assoc_cache: RTL and testbench

//  Parameterised write-back, write-allocate, set-associative cache with LRU replacement.

---
 rtl/set_assoc_cache_if.sv | 13 +
 rtl/set_assoc_cache.sv | 182 ++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/set_assoc_cache_if.sv
// Single-word re/we/ready handshake bus, used on both the requester and backing-memory sides.
// din carries write data master->slave, dout carries read data slave->master.
interface set_assoc_cache_if;
  logic [63:0] addr;
  logic [63:0] din;
  logic [63:0] dout;
  logic        re;
  logic        we;
  logic        ready;

  modport master (output addr, din, re, we, input dout, ready);
  modport slave  (input addr, din, re, we, output dout, ready);
endinterface

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate set-associative cache with per-set LRU age counters.
// States: IDLE accept | LOOKUP tag compare / hit service | WB dirty victim out | FILL line in.
module set_assoc_cache #(
  parameter int LINE_SIZE_BITS  = 1,
  parameter int LINE_COUNT_BITS = 4,
  parameter int ASSOC_BITS      = 2
) (
  input logic                 clk,
  input logic                 rst,
  set_assoc_cache_if.slave    cpu,
  set_assoc_cache_if.master   mem
);
  localparam int WPL       = 1 << LINE_SIZE_BITS;
  localparam int WAYS      = 1 << ASSOC_BITS;
  localparam int SET_BITS  = LINE_COUNT_BITS - ASSOC_BITS;
  localparam int SETS      = 1 << SET_BITS;
  localparam int TAG_SHIFT = LINE_SIZE_BITS + SET_BITS;
  localparam int TAG_BITS  = 64 - TAG_SHIFT;
  localparam int OW        = (LINE_SIZE_BITS > 0) ? LINE_SIZE_BITS : 1;
  localparam int SW        = (SET_BITS > 0) ? SET_BITS : 1;
  localparam int WW        = (ASSOC_BITS > 0) ? ASSOC_BITS : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, FILL} state_t;

  logic [63:0]         data  [SETS][WAYS][WPL];
  logic [TAG_BITS-1:0] tags  [SETS][WAYS];
  logic                valid [SETS][WAYS];
  logic                dirty [SETS][WAYS];
  logic [WW-1:0]       age   [SETS][WAYS];

  state_t        state;
  logic [63:0]   req_addr, req_din;
  logic          req_we;
  logic [WW-1:0] victim;
  logic [OW-1:0] cnt;
  logic          pend;
  logic          ready_q, mem_re_q, mem_we_q;
  logic [63:0]   dout_q, mem_addr_q, mem_din_q;

  logic [OW-1:0]       req_off;
  logic [SW-1:0]       req_set;
  logic [TAG_BITS-1:0] req_tag;
  logic                hit, found_inv, last_word, mem_word_done;
  logic [WW-1:0]       hit_way, vict_c;

  assign req_off   = OW'(req_addr & 64'(WPL - 1));
  assign req_set   = SW'((req_addr >> LINE_SIZE_BITS) & 64'(SETS - 1));
  assign req_tag   = TAG_BITS'(req_addr >> TAG_SHIFT);
  assign last_word = (cnt == OW'(WPL - 1));
  assign mem_word_done = pend && mem.ready;

  assign cpu.ready = ready_q;
  assign cpu.dout  = dout_q;
  assign mem.addr  = mem_addr_q;
  assign mem.din   = mem_din_q;
  assign mem.re    = mem_re_q;
  assign mem.we    = mem_we_q;

  function automatic logic [63:0] line_addr(input logic [TAG_BITS-1:0] t,
                                            input logic [SW-1:0] s,
                                            input logic [OW-1:0] o);
    return (64'(t) << TAG_SHIFT) | (64'(s) << LINE_SIZE_BITS) | 64'(o);
  endfunction

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    vict_c    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid[req_set][w] && tags[req_set][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!found_inv && !valid[req_set][w]) begin
        found_inv = 1'b1;
        vict_c    = WW'(w);
      end
    end
    if (!found_inv)
      for (int w = 0; w < WAYS; w++)
        if (age[req_set][w] > age[req_set][vict_c]) vict_c = WW'(w);
  end

  // Line storage carries no reset; validity is tracked by the valid bits.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && req_we)
      data[req_set][hit_way][req_off] <= req_din;
    if (state == FILL && mem_word_done) begin
      data[req_set][victim][cnt] <= mem.dout;
      if (last_word) tags[req_set][victim] <= req_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ready_q    <= 1'b1;
      dout_q     <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      req_addr   <= '0;
      req_din    <= '0;
      req_we     <= 1'b0;
      victim     <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
          age[s][w]   <= '0;
        end
    end else begin
      case (state)
        IDLE: if (cpu.we || cpu.re) begin
          req_addr <= cpu.addr;
          req_din  <= cpu.din;
          req_we   <= cpu.we;
          ready_q  <= 1'b0;
          state    <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          if (req_we) dirty[req_set][hit_way] <= 1'b1;
          else        dout_q <= data[req_set][hit_way][req_off];
          for (int w = 0; w < WAYS; w++)
            if (WW'(w) == hit_way) age[req_set][w] <= '0;
            else if (age[req_set][w] < age[req_set][hit_way])
              age[req_set][w] <= age[req_set][w] + 1'b1;
          ready_q <= 1'b1;
          state   <= IDLE;
        end else begin
          victim <= vict_c;
          cnt    <= '0;
          pend   <= 1'b0;
          valid[req_set][vict_c] <= 1'b0;
          state  <= (valid[req_set][vict_c] && dirty[req_set][vict_c]) ? WB : FILL;
        end
        WB: begin
          if (!pend && !mem_we_q) begin
            if (mem.ready) begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= line_addr(tags[req_set][victim], req_set, cnt);
              mem_din_q  <= data[req_set][victim][cnt];
            end
          end else if (mem_we_q) begin
            mem_we_q <= 1'b0;
            pend     <= 1'b1;
          end else if (mem.ready) begin
            pend <= 1'b0;
            cnt  <= last_word ? '0 : cnt + 1'b1;
            if (last_word) state <= FILL;
          end
        end
        FILL: begin
          if (!pend && !mem_re_q) begin
            if (mem.ready) begin
              mem_re_q   <= 1'b1;
              mem_addr_q <= line_addr(req_tag, req_set, cnt);
            end
          end else if (mem_re_q) begin
            mem_re_q <= 1'b0;
            pend     <= 1'b1;
          end else if (mem.ready) begin
            pend <= 1'b0;
            cnt  <= last_word ? '0 : cnt + 1'b1;
            if (last_word) begin
              valid[req_set][victim] <= 1'b1;
              dirty[req_set][victim] <= 1'b0;
              // Treat the new line as oldest so the re-lookup ages every other way.
              age[req_set][victim]   <= '1;
              state                  <= LOOKUP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench: reference word model plus scoreboard of expected read data, and a
// backing ram with variable wait states that also checks the downstream handshake.
module tb_set_assoc_cache;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  set_assoc_cache_if cpu();
  set_assoc_cache_if mem();

  set_assoc_cache dut (.clk(clk), .rst(rst), .cpu(cpu), .mem(mem));

  int tests = 0;
  int fails = 0;
  logic [63:0] model [logic [63:0]];
  logic [63:0] ram   [logic [63:0]];
  logic [63:0] exp_q [$];

  logic        ram_busy  = 1'b0;
  int          ram_delay = 0;
  logic [63:0] ram_q     = '0;
  assign mem.ready = !ram_busy;
  assign mem.dout  = ram_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input logic [63:0] a);
    return model.exists(a) ? model[a] : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  always @(posedge clk) begin
    if (mem.re || mem.we) begin
      check("strobe_while_busy", {63'b0, ram_busy}, 64'd0);
      check("both_strobes", {63'b0, mem.re && mem.we}, 64'd0);
    end
    if (ram_busy) begin
      if (ram_delay == 0) ram_busy <= 1'b0;
      else                ram_delay <= ram_delay - 1;
    end else if (mem.we) begin
      ram[mem.addr] = mem.din;
      ram_busy  <= 1'b1;
      ram_delay <= int'($urandom_range(2, 0));
    end else if (mem.re) begin
      ram_q     <= ram.exists(mem.addr) ? ram[mem.addr] : 64'hFFFF_FFFF_FFFF_FFFF;
      ram_busy  <= 1'b1;
      ram_delay <= int'($urandom_range(2, 0));
    end
  end

  // Issues one request at a negedge, then counts the cycles ready stays low.
  task automatic do_op(input string tag, input bit wr, input logic [63:0] a,
                       input logic [63:0] d, output int lat);
    @(negedge clk);
    cpu.addr = a;
    cpu.din  = d;
    cpu.we   = wr;
    cpu.re   = !wr;
    if (wr) model[a] = d;
    else    exp_q.push_back(model_rd(a));
    @(negedge clk);
    cpu.re = 1'b0;
    cpu.we = 1'b0;
    lat = 1;
    while (!cpu.ready && lat < 300) begin
      @(negedge clk);
      if (!cpu.ready) lat++;
    end
    if (cpu.ready === 1'b1 && lat == 1 && !wr) lat = 1;
    check({tag, "_done"}, {63'b0, cpu.ready}, 64'd1);
    if (!wr) check(tag, cpu.dout, exp_q.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    rst      = 1'b1;
    cpu.re   = 1'b0;
    cpu.we   = 1'b0;
    cpu.addr = '0;
    cpu.din  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {63'b0, cpu.ready}, 64'd1);
    check("rst_dout", cpu.dout, 64'd0);
    check("rst_mem_re", {63'b0, mem.re}, 64'd0);
    check("rst_mem_we", {63'b0, mem.we}, 64'd0);
    check("rst_mem_addr", mem.addr, 64'd0);
    check("rst_mem_din", mem.din, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {63'b0, cpu.ready}, 64'd1);
    check("post_rst_strobes", {62'b0, mem.re, mem.we}, 64'd0);

    do_op("wr1_miss", 1'b1, 64'd1, 64'h0123_4567_89ab_cdef, lat);
    check("wr1_miss_lat_gt1", {63'b0, lat > 1}, 64'd1);
    do_op("rd1_hit", 1'b0, 64'd1, '0, lat);
    check("rd1_hit_lat", 64'(lat), 64'd1);
    do_op("rd0_same_line", 1'b0, 64'd0, '0, lat);
    check("rd0_hit_lat", 64'(lat), 64'd1);

    do_op("wr257", 1'b1, 64'd257, 64'd123, lat);
    do_op("rd257_hit", 1'b0, 64'd257, '0, lat);
    check("rd257_hit_lat", 64'(lat), 64'd1);
    do_op("rd1_again", 1'b0, 64'd1, '0, lat);
    check("rd1_again_lat", 64'(lat), 64'd1);

    do_op("wr256", 1'b1, 64'd256, 64'd321, lat);
    for (int i = 1; i <= 5; i++)
      do_op("wr_set0_fill", 1'b1, 64'(i * 8), 64'h1000 + 64'(i), lat);
    do_op("rd1_evicted", 1'b0, 64'd1, '0, lat);
    do_op("rd256_after", 1'b0, 64'd256, '0, lat);
    do_op("rd257_after", 1'b0, 64'd257, '0, lat);
    for (int i = 1; i <= 5; i++)
      do_op("rd_set0_line", 1'b0, 64'(i * 8), '0, lat);

    do_op("wr1_over", 1'b1, 64'd1, 64'd5, lat);
    do_op("rd1_over", 1'b0, 64'd1, '0, lat);
    do_op("rd257_final", 1'b0, 64'd257, '0, lat);
    do_op("rd256_final", 1'b0, 64'd256, '0, lat);

    // Reset in the middle of a line fill for a new set-0 line.
    @(negedge clk);
    cpu.addr = 64'd48;
    cpu.re   = 1'b1;
    @(negedge clk);
    cpu.re = 1'b0;
    n = 0;
    while (!mem.re && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("fill_started", {63'b0, mem.re}, 64'd1);
    rst = 1'b1;
    #1;
    check("midfill_rst_ready", {63'b0, cpu.ready}, 64'd1);
    check("midfill_rst_mem_re", {63'b0, mem.re}, 64'd0);
    check("midfill_rst_mem_we", {63'b0, mem.we}, 64'd0);
    check("midfill_rst_dout", cpu.dout, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rerelease_ready", {63'b0, cpu.ready}, 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
